// File: rtl/scope_pkg.sv
// scope_pkg: constants and FSM encoding shared by the capture stage and the display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scope_pkg;

  localparam int SAMPLE_W = 16;   // signed generator sample width
  localparam int DEPTH    = 640;  // one sample per visible VGA column
  localparam int ADDR_W   = 10;   // 2**ADDR_W >= DEPTH
  localparam int DECIM_W  = 8;    // decimation control width
  localparam int CNT_W    = 16;   // completed-capture counter width

  typedef enum logic [1:0] {
    ARM,
    WAIT,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/scope_trigger_capture_if.sv
// scope_trigger_capture_if: generator-in / display-out bundle of the capture stage.
// Latency: n/a (wiring only); rd_data trails rd_addr by one clock inside the stage.
// Backpressure: none; the display gates its reads on capture_valid.
interface scope_trigger_capture_if;
  import scope_pkg::*;

  logic signed [SAMPLE_W-1:0] signal;
  logic signed [SAMPLE_W-1:0] trig_level;
  logic        [DECIM_W-1:0]  decim;
  logic        [ADDR_W-1:0]   rd_addr;
  logic signed [SAMPLE_W-1:0] rd_data;
  logic                       frame_done;
  logic                       capture_valid;
  logic                       auto_trig;
  logic        [CNT_W-1:0]    trig_count;

  // Generator/display side
  modport master (
    output signal, trig_level, decim, rd_addr, frame_done,
    input  rd_data, capture_valid, auto_trig, trig_count
  );

  // Capture stage side
  modport slave (
    input  signal, trig_level, decim, rd_addr, frame_done,
    output rd_data, capture_valid, auto_trig, trig_count
  );

endinterface

// File: rtl/scope_trigger_capture_ram.sv
// capture_ram: DEPTH x SAMPLE_W simple dual-port buffer, one write port, one registered read port.
// Latency: write lands on the clock edge; read data appears 1 clock after the address.
// Backpressure: none; a same-address read/write returns the old contents.
module capture_ram
  import scope_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_we,
  input  logic        [ADDR_W-1:0]   i_waddr,
  input  logic signed [SAMPLE_W-1:0] i_wdata,
  input  logic        [ADDR_W-1:0]   i_raddr,
  output logic signed [SAMPLE_W-1:0] o_rdata
);

  logic signed [SAMPLE_W-1:0] r_mem [DEPTH];
  logic signed [SAMPLE_W-1:0] r_rdata;
  logic                       w_oob;

  // Columns beyond the visible screen read as zero
  assign w_oob = (i_raddr >= ADDR_W'(DEPTH));

  // Write port; contents are deliberately left unreset
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; non-blocking update gives old-data-on-collision
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_rdata <= '0;
    else if (w_oob) r_rdata <= '0;
    else            r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/scope_trigger_capture.sv
// scope_trigger_capture: decimate, wait for a rising level crossing, capture DEPTH samples, freeze for display.
// Latency: trigger sample written on its own strobe; capture_valid 1 clock after HOLD entry; rd_data 1 clock after rd_addr.
// Backpressure: none; buffer stays frozen until two frame_done pulses. SCOPE_AUTO_TRIG_EN adds a timeout auto-trigger.
module scope_trigger_capture
  import scope_pkg::*;
`ifdef SCOPE_AUTO_TRIG_EN
#(
  parameter int AUTO_TIMEOUT = 4096
)
`endif
(
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  scope_trigger_capture_if.slave sc
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DECIM_W-1:0]  r_dcnt;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   w_waddr;
  logic [CNT_W-1:0]    r_trig_count;
  logic                r_frame_cnt;
  logic                r_capture_valid;
  logic                w_strobe;
  logic                w_below;
  logic                w_we;
  logic                w_real_trig;
  logic                w_auto_fire;
  logic                w_tmo_hit;
  logic                w_fd_count;

  // >= keeps the strobe alive if decim is lowered below the running count
  assign w_strobe   = (r_dcnt >= sc.decim);
  assign w_below    = ($signed(sc.signal) < $signed(sc.trig_level));
  // capture_valid is low on the HOLD entry cycle, so that cycle's pulse is dropped
  assign w_fd_count = sc.frame_done && r_capture_valid;

  // Decimation counter: free-running, restarts after every strobe
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)         r_dcnt <= '0;
    else if (w_strobe) r_dcnt <= '0;
    else               r_dcnt <= r_dcnt + 1'b1;
  end

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_auto_trig;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(AUTO_TIMEOUT - 1));

  // Strobes spent hunting for a trigger; any state change restarts the count
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)                                           r_tmo_cnt <= '0;
    else if (w_state_nxt != r_state)                     r_tmo_cnt <= '0;
    else if (w_strobe && (r_state == ARM || r_state == WAIT)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Remember whether the current/last capture was forced by the timeout
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)            r_auto_trig <= 1'b0;
    else if (w_auto_fire) r_auto_trig <= 1'b1;
    else if (w_real_trig) r_auto_trig <= 1'b0;
  end

  assign sc.auto_trig = r_auto_trig;
`else
  assign w_tmo_hit    = 1'b0;
  assign sc.auto_trig = 1'b0;
`endif

  // Next state and buffer write control; trigger sample is written on the detecting strobe
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_wr_addr;
    w_real_trig = 1'b0;
    w_auto_fire = 1'b0;
    case (r_state)
      ARM: begin
        if (w_strobe) begin
          if (w_below)        w_state_nxt = WAIT;
          else if (w_tmo_hit) w_auto_fire = 1'b1;
        end
      end
      WAIT: begin
        if (w_strobe) begin
          if (!w_below)       w_real_trig = 1'b1;
          else if (w_tmo_hit) w_auto_fire = 1'b1;
        end
      end
      CAPTURE: begin
        if (w_strobe) begin
          w_we = 1'b1;
          if (r_wr_addr == ADDR_W'(DEPTH - 1)) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_fd_count && r_frame_cnt) w_state_nxt = ARM;
      end
      default: w_state_nxt = ARM;
    endcase
    if (w_real_trig || w_auto_fire) begin
      w_we        = 1'b1;
      w_waddr     = '0;
      w_state_nxt = CAPTURE;
    end
  end

  // State, write pointer, frame handshake and capture bookkeeping
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state         <= ARM;
      r_wr_addr       <= '0;
      r_frame_cnt     <= 1'b0;
      r_capture_valid <= 1'b0;
      r_trig_count    <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_capture_valid <= (r_state == HOLD) && (w_state_nxt == HOLD);
      if (w_we) r_wr_addr <= w_waddr + 1'b1;
      if (r_state == CAPTURE && w_state_nxt == HOLD) r_trig_count <= r_trig_count + 1'b1;
      if (w_state_nxt != HOLD) r_frame_cnt <= 1'b0;
      else if (w_fd_count)     r_frame_cnt <= 1'b1;
    end
  end

  capture_ram u_ram (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (sc.signal),
    .i_raddr (sc.rd_addr),
    .o_rdata (sc.rd_data)
  );

  assign sc.capture_valid = r_capture_valid;
  assign sc.trig_count    = r_trig_count;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// tb_scope_trigger_capture: directed + randomized bench against a stimulus-level reference model.
// Latency: checks rd_data 1 clock after rd_addr and capture_valid timing relative to the trigger strobe.
// Backpressure: exercises the two-frame release of the frozen buffer.
module tb_scope_trigger_capture;
  import scope_pkg::*;

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int AUTO = 16;
`else
  localparam int AUTO = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic signed [SAMPLE_W-1:0] stim[$];
  logic                       cvh[$];
  int                         cur_decim;
  logic signed [SAMPLE_W-1:0] cur_level;

  scope_trigger_capture_if sc();

`ifdef SCOPE_AUTO_TRIG_EN
  scope_trigger_capture #(.AUTO_TIMEOUT(AUTO)) dut (.CLOCK_50(clk), .RESET(rst), .sc(sc));
`else
  scope_trigger_capture dut (.CLOCK_50(clk), .RESET(rst), .sc(sc));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: present a sample (and optional frame_done), then sample outputs 1ns after the edge
  task automatic step(input logic signed [SAMPLE_W-1:0] s, input bit fd);
    sc.signal     = s;
    sc.frame_done = fd;
    @(posedge clk);
    #1;
    cvh.push_back(sc.capture_valid);
    sc.frame_done = 1'b0;
  endtask

  task automatic reset_hold(input int d, input int lvl);
    rst           = 1'b1;
    cur_decim     = d;
    cur_level     = SAMPLE_W'(lvl);
    sc.decim      = DECIM_W'(d);
    sc.trig_level = SAMPLE_W'(lvl);
    sc.signal     = '0;
    sc.frame_done = 1'b0;
    sc.rd_addr    = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic void build_ramp(input int start, input int n);
    stim.delete();
    for (int k = 0; k < n; k++) stim.push_back(SAMPLE_W'(start + k));
  endfunction

  // Reference: walk the strobed samples, find below -> not-below (or a timeout) and return its clock index
  function automatic int find_trigger(output bit is_auto);
    int n;
    bit seen_below;
    n          = 0;
    seen_below = 1'b0;
    is_auto    = 1'b0;
    for (int k = cur_decim; k < stim.size(); k += cur_decim + 1) begin
      n++;
      if (!seen_below) begin
        if (stim[k] < cur_level) begin
          seen_below = 1'b1;
          n = 0;
        end else if (AUTO > 0 && n == AUTO) begin
          is_auto = 1'b1;
          return k;
        end
      end else begin
        if (!(stim[k] < cur_level)) return k;
        if (AUTO > 0 && n == AUTO) begin
          is_auto = 1'b1;
          return k;
        end
      end
    end
    return -1;
  endfunction

  function automatic int first_high();
    foreach (cvh[i]) if (cvh[i]) return i;
    return -1;
  endfunction

  task automatic run_stim(input int fd_at);
    cvh.delete();
    foreach (stim[k]) step(stim[k], k == fd_at);
  endtask

  task automatic rd_chk(input string tag, input int a, input int t);
    logic signed [31:0] e;
    if (a < DEPTH) e = stim[t + a * (cur_decim + 1)];
    else           e = 0;
    sc.rd_addr = ADDR_W'(a);
    step('0, 1'b0);
    chk($sformatf("%s_rd%0d", tag, a), sc.rd_data, e);
  endtask

  // Compare DUT against the model after a stimulus run; reads only make sense if a capture froze
  task automatic check_capture(input string tag, input int nreads);
    bit a;
    int t;
    int exp_rise;
    t        = find_trigger(a);
    exp_rise = (t < 0) ? -1 : t + (DEPTH - 1) * (cur_decim + 1) + 1;
    chk({tag, "_rise"}, first_high(), exp_rise);
    chk({tag, "_count"}, sc.trig_count, (t < 0) ? 0 : 1);
    chk({tag, "_auto"}, sc.auto_trig, (t < 0) ? 0 : a);
    if (t >= 0) begin
      rd_chk(tag, 0, t);
      rd_chk(tag, 5, t);
      rd_chk(tag, DEPTH - 1, t);
      rd_chk(tag, DEPTH, t);
      rd_chk(tag, 700, t);
      for (int i = 0; i < nreads; i++) rd_chk(tag, $urandom_range(0, DEPTH - 1), t);
    end
  endtask

  initial begin
    int t;
    bit a;
    int d;

    // Reset values
    reset_hold(0, 0);
    chk("rst_capture_valid", sc.capture_valid, 0);
    chk("rst_trig_count", sc.trig_count, 0);
    chk("rst_auto_trig", sc.auto_trig, 0);
    chk("rst_rd_data", sc.rd_data, 0);
    rst = 1'b0;

    // Ramp, decim 0; frame_done on the HOLD-entry cycle must not count
    build_ramp(-1000, 2001);
    t = find_trigger(a);
    run_stim((t >= 0) ? t + DEPTH : -1);
    check_capture("ramp0", 16);
    step('0, 1'b1);
    repeat (3) step('0, 1'b0);
    chk("hold_after_1fd", sc.capture_valid, 1);
    step('0, 1'b1);
    chk("arm_after_2fd", sc.capture_valid, 0);

    // Second ramp from ARM, aborted by reset at capture sample 300
    build_ramp(-1000, 2001);
    t = find_trigger(a);
    for (int k = 0; k <= t + 300; k++) step(stim[k], 1'b0);
    chk("pre_reset_count", sc.trig_count, 1);
    rst = 1'b1;
    #1;
    chk("abort_capture_valid", sc.capture_valid, 0);
    chk("abort_trig_count", sc.trig_count, 0);
    chk("abort_auto_trig", sc.auto_trig, 0);
    chk("abort_rd_data", sc.rd_data, 0);
    reset_hold(0, 0);
    rst = 1'b0;
    build_ramp(-1000, 2001);
    run_stim(-1);
    check_capture("rerun", 8);

    // Same ramp, decim 3
    reset_hold(3, 0);
    rst = 1'b0;
    build_ramp(-1000, 3700);
    run_stim(-1);
    check_capture("decim3", 8);

    // Flat signal above the level: no trigger unless the timeout is built in
    d = $urandom_range(0, 2);
    reset_hold(d, 0);
    rst = 1'b0;
    stim.delete();
    for (int k = 0; k < 2000; k++) stim.push_back(SAMPLE_W'(500));
    run_stim(-1);
    check_capture("flat", 4);

    // Random samples, random level and decimation
    for (int r = 0; r < 2; r++) begin
      reset_hold($urandom_range(0, 3), int'($urandom_range(0, 1000)) - 500);
      rst = 1'b0;
      stim.delete();
      for (int k = 0; k < 3200; k++) stim.push_back(SAMPLE_W'(int'($urandom_range(0, 4000)) - 2000));
      run_stim(-1);
      check_capture($sformatf("rand%0d", r), 24);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scope_trigger_capture.md
# scope_trigger_capture

Trigger-and-capture stage between the signal generator and the oscilloscope display. It samples the 16-bit generator output at a programmable decimation rate, waits for a rising crossing of a trigger level, and captures one screen of samples (one per VGA column). It then freezes the buffer so the display can read a stable trace by column address. Display reads are released for the next capture only after the display has finished a complete frame.

## Interface
- SAMPLE_W, 16, sample width; two's-complement signed.
- DEPTH, 640, samples per capture, one per visible VGA column.
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= DEPTH.
- DECIM_W, 8, decimation control width.
- AUTO_TIMEOUT, 4096, strobes without a trigger before an auto capture. Used only with SCOPE_AUTO_TRIG_EN.

- CLOCK_50  in  1  system clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- signal  in  SAMPLE_W  generator output, signed.
- trig_level  in  SAMPLE_W  signed trigger threshold.
- decim  in  DECIM_W  sample on every (decim+1)th clock.
- rd_addr  in  ADDR_W  display column address.
- rd_data  out  SAMPLE_W  registered buffer read data.
- frame_done  in  1  one-cycle pulse from the display at end of frame.
- capture_valid  out  1  buffer holds a complete, frozen capture.
- auto_trig  out  1  current or last capture was forced by timeout.
- trig_count  out  16  completed captures; wraps at 65535 to 0.

## Operation
- Decimator: `dcnt` counts up each clock. When `dcnt >= decim`, it produces a one-cycle strobe and clears to 0. Using >= keeps the strobe safe when `decim` is lowered mid-count. With `decim = 0`, the strobe fires every clock.
- All trigger logic and buffer writes act only on strobe cycles. The sample is `signal` as seen on the strobe cycle.
- `below` = signed compare (`signal < trig_level`).
- FSM states, evaluated on strobe cycles unless noted:
  - ARM: if `below`, go to WAIT.
  - WAIT: if `!below`, a rising crossing has occurred:
    - write the sample to address 0;
    - set `wr_addr` = 1;
    - go to CAPTURE.
  - CAPTURE: write the sample to `wr_addr` and increment `wr_addr`. After the write at DEPTH-1, go to HOLD:
    - `capture_valid` rises;
    - `trig_count` increments.
  - HOLD: evaluated every clock, not on strobes. Ignores strobes. Counts `frame_done` pulses; on the 2nd pulse, go to ARM.
    - `capture_valid` falls.
    - The frame counter clears.
    - This guarantees at least one full frame is displayed.
- A `frame_done` pulse in the same cycle HOLD is entered is not counted. `frame_done` is ignored in all other states.
- Read port: `rd_data` = `buf[rd_addr]`, registered, 1-cycle latency, readable in every state.
  - Outside HOLD the contents are partially overwritten. The display must gate on `capture_valid`.
  - `rd_addr >= DEPTH` returns 0.
- Read/write to the same address in the same cycle returns the old data.

## Timing
- Reset values:
  - state = ARM;
  - `dcnt`, `wr_addr`, frame counter, timeout counter = 0;
  - `capture_valid` = 0, `auto_trig` = 0, `trig_count` = 0, `rd_data` = 0.
  - Buffer contents are not reset.
- RESET asserted mid-CAPTURE or mid-HOLD aborts immediately. After release, the FSM starts at ARM with `capture_valid` = 0.
- Trigger-to-write latency: the trigger sample is written in the same clock the crossing is detected.
- Capture duration: exactly DEPTH strobes, including the trigger strobe. With `decim = 0`, HOLD is entered DEPTH clocks after the trigger strobe, and `capture_valid` is 1 on the following clock.
- A level exactly equal to `trig_level` counts as not-below.

## Configuration
- SCOPE_AUTO_TRIG_EN defined:
  - A timeout counter counts strobes while in ARM or WAIT. It clears on any state entry.
  - On reaching AUTO_TIMEOUT, the FSM enters CAPTURE with the current sample at address 0 and sets `auto_trig` = 1.
  - A real trigger clears `auto_trig` to 0.
- SCOPE_AUTO_TRIG_EN undefined: no timeout counter, and `auto_trig` is tied to 0. A flat signal stalls in ARM/WAIT forever.

## Structure
- Shared package `scope_pkg` contains:
  - the state enum (ARM, WAIT, CAPTURE, HOLD);
  - the SAMPLE_W, DEPTH and ADDR_W constants, reused by the display.
- One sub-module, `capture_ram`: simple dual-port RAM with 1 write port and 1 registered read port, sized DEPTH × SAMPLE_W, inferable as block RAM.

## Test plan
- Ramp −1000→+1000, step 1 per clock; `trig_level` = 0; `decim` = 0 → `buf[0]` = 0, `buf[639]` = 639; `capture_valid` rises 641 clocks after the trigger clock.
- `decim` = 3, same ramp → strobes every 4th clock; `buf[k]` = 4k + offset of the first strobed sample ≥ 0; `trig_count` = 1.
- Hold a constant 500 with level 0 → never triggers. Without the macro, state stays in ARM. With the macro and AUTO_TIMEOUT = 16, a capture starts after 16 strobes with `auto_trig` = 1.
- In HOLD, pulse `frame_done` once → still HOLD. Second pulse → ARM next clock, `capture_valid` = 0. A pulse on the HOLD-entry cycle is not counted.
- Assert RESET at capture sample 300 → all outputs return to reset values. Re-run the ramp → a normal capture with `trig_count` = 1.
- Read `rd_addr` = 5 and `rd_addr` = 700 in HOLD → `buf[5]` one clock later, and 0 for address 700.
